// File: rtl/led_mode_seq_pkg.sv
// Shared constants, state type and wrap-around helpers for the LED mode sequencer.
package led_mode_seq_pkg;

    // Width of the LED pattern code driven to the pattern stage.
    localparam int STATE_W = 4;

    // Highest legal pattern code; codes 0..STATE_MAX are legal.
    localparam int STATE_MAX = 13;

    typedef logic [STATE_W-1:0] state_t;

    // Named pattern codes used by the LED pattern stage.
    localparam state_t ST_ALL     = state_t'(0);
    localparam state_t ST_FULL_ON = state_t'(7);
    localparam state_t ST_PAIR    = state_t'(13);

    // Step forward, wrapping from last_code back to ST_ALL.
    function automatic state_t step_up(input state_t cur, input state_t last_code);
        return (cur >= last_code) ? ST_ALL : cur + state_t'(1);
    endfunction

    // Step backward, wrapping from ST_ALL up to last_code.
    function automatic state_t step_down(input state_t cur, input state_t last_code);
        return (cur == ST_ALL) ? last_code : cur - state_t'(1);
    endfunction

endpackage

// File: rtl/led_mode_seq_if.sv
// Button inputs and pattern outputs of the LED mode sequencer, bundled for connection.
interface led_mode_seq_if;
    import led_mode_seq_pkg::*;

    logic   btn_next;
    logic   btn_prev;
    logic   btn_auto;
    state_t state;
    logic   state_chg;
    logic   auto_on;

    // Side that presses the buttons and watches the pattern code.
    modport master (
        output btn_next, btn_prev, btn_auto,
        input  state, state_chg, auto_on
    );

    // Sequencer side.
    modport slave (
        input  btn_next, btn_prev, btn_auto,
        output state, state_chg, auto_on
    );

endinterface

// File: rtl/led_btn_debounce.sv
// One push button: 2-flop synchronizer, stable-level debouncer and a one-cycle
// press pulse on the accepted 0->1 edge. Releases produce no pulse.
module led_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_0;
    logic             sync_1;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             press_q;

    // Bring the raw asynchronous button into the clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= btn;
            sync_1 <= sync_0;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive
    // cycles; any return to the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= 1'b0;
            cnt     <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync_1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level   <= sync_1;
                cnt     <= '0;
                press_q <= sync_1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_mode_seq.sv
// LED mode sequencer: three debounced buttons step a pattern code forward/back
// with wrap-around, and an optional auto mode advances it on a fixed period.
module led_mode_seq #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_CYCLES     = 100000000,
    parameter int STATE_MAX       = 13
) (
    input logic           clk,
    input logic           rst,
    led_mode_seq_if.slave bus
);
    import led_mode_seq_pkg::*;

    localparam int AUTO_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);
    localparam state_t STATE_LAST = state_t'(STATE_MAX);

    logic press_next;
    logic press_prev;
    logic press_auto;

    state_t            state_q;
    state_t            state_d;
    logic              chg_q;
    logic              chg_d;
    logic              auto_q;
    logic              auto_d;
    logic [AUTO_W-1:0] timer_q;
    logic [AUTO_W-1:0] timer_d;

    logic manual;
    logic tc;

    led_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_next),
        .press (press_next)
    );

    led_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_prev),
        .press (press_prev)
    );

    led_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_auto (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_auto),
        .press (press_auto)
    );

    assign manual = press_next | press_prev;
    assign tc     = auto_q && (timer_q == AUTO_LAST);

    // Decide the next pattern code, change pulse, auto flag and auto timer.
    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        chg_d   = 1'b0;
        auto_d  = auto_q;
        timer_d = (auto_q && !tc) ? timer_q + AUTO_W'(1) : '0;

        // Any manual press restarts the auto period.
        if (manual) begin
            timer_d = '0;
        end

        if (press_auto) begin
            auto_d  = ~auto_q;
            timer_d = '0;
        end

        if (state_q > STATE_LAST) begin
            // Recover from an illegal code immediately.
            state_d = ST_ALL;
            chg_d   = 1'b1;
        end else if (press_next && !press_prev) begin
            state_d = step_up(state_q, STATE_LAST);
            chg_d   = 1'b1;
        end else if (press_prev && !press_next) begin
            state_d = step_down(state_q, STATE_LAST);
            chg_d   = 1'b1;
        end else if (tc && !manual) begin
            // A manual press in the same cycle (even a cancelling pair) discards the auto step.
            state_d = step_up(state_q, STATE_LAST);
            chg_d   = 1'b1;
        end
    end

    // Register the pattern code and control flags; reset beats every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ALL;
            chg_q   <= 1'b0;
            auto_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            chg_q   <= chg_d;
            auto_q  <= auto_d;
            timer_q <= timer_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.state_chg = chg_q;
    assign bus.auto_on   = auto_q;

endmodule
